// File: rtl/mips_ctrl_pkg.sv
// Shared multicycle MIPS control encodings: states, opcodes, ALU ops.
// ILLEGAL_TRAP_EN adds the ERR trap state for unknown opcodes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12
`ifdef ILLEGAL_TRAP_EN
    ,
    S_ERR     = 4'd13
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SUBNE = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_AND   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  function automatic logic [2:0] imm_aluop(input logic [5:0] o);
    case (o)
      OP_ANDI: imm_aluop = ALU_AND;
      OP_ORI:  imm_aluop = ALU_OR;
      OP_SLTI: imm_aluop = ALU_SLT;
      default: imm_aluop = ALU_ADD;
    endcase
  endfunction

  function automatic logic imm_zext(input logic [5:0] o);
    imm_zext = (o == OP_ANDI) || (o == OP_ORI);
  endfunction

endpackage

// File: rtl/mainfsm.sv
// Multicycle MIPS main control FSM (Moore), memready-qualified fetch.
// ILLEGAL_TRAP_EN: unknown opcodes trap in ERR with sticky illegal.
module mainfsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       regdst,
  output logic       branch,
  output logic       branchne,
  output logic       zeroext,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     cur;
  state_t     nxt;
  logic [2:0] immaluop;
  logic       immzext;

  assign state = cur;

  always_comb begin
    nxt = S_FETCH;
    unique case (cur)
      S_FETCH:   nxt = memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_RTYPEEX;
          OP_BEQ:       nxt = S_BEQEX;
          OP_BNE:       nxt = S_BNEEX;
          OP_ADDI, OP_ANDI,
          OP_ORI, OP_SLTI: nxt = S_IMMEX;
          OP_J:         nxt = S_JEX;
`ifdef ILLEGAL_TRAP_EN
          default:      nxt = S_ERR;
`else
          default:      nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = memready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   nxt = memready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: nxt = S_RTYPEWB;
      S_RTYPEWB: nxt = S_FETCH;
      S_BEQEX:   nxt = S_FETCH;
      S_BNEEX:   nxt = S_FETCH;
      S_IMMEX:   nxt = S_IMMWB;
      S_IMMWB:   nxt = S_FETCH;
      S_JEX:     nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_ERR:     nxt = S_ERR;
`endif
      default:   nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= S_FETCH;
      immaluop <= ALU_ADD;
      immzext  <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        immaluop <= imm_aluop(op);
        immzext  <= imm_zext(op);
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal <= 1'b0;
    else if (nxt == S_ERR)
      illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  // Write strobes are additionally gated by reset so nothing commits
  // while reset is held, even though FETCH qualifies on memready.
  always_comb begin
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    zeroext  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    unique case (cur)
      S_FETCH: begin
        alusrcb = 2'b01;
        pcwrite = memready && !reset;
        irwrite = memready && !reset;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = !reset;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = !reset;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = !reset;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_BNEEX: begin
        alusrca  = 1'b1;
        aluop    = ALU_SUBNE;
        pcsrc    = 2'b01;
        branchne = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = immaluop;
        zeroext = immzext;
      end
      S_IMMWB: regwrite = !reset;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = !reset;
      end
`ifdef ILLEGAL_TRAP_EN
      S_ERR: ;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for mainfsm: fetch stall, lw, R-type, imm, bne, j,
// async reset mid-MEMRD and unknown-opcode handling.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic       memready = 1'b0;
  logic       pcwrite, irwrite, regwrite, memwrite, iord, alusrca;
  logic       memtoreg, regdst, branch, branchne, zeroext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite),
    .memwrite(memwrite), .iord(iord), .alusrca(alusrca),
    .memtoreg(memtoreg), .regdst(regdst), .branch(branch),
    .branchne(branchne), .zeroext(zeroext), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_state", {4'd0, state}, 8'd0);
    chk("rst_illegal", {7'd0, illegal}, 8'd0);
    memready = 1'b1;
    #1;
    chk("rst_irwrite_gated", {7'd0, irwrite}, 8'd0);
    chk("rst_pcwrite_gated", {7'd0, pcwrite}, 8'd0);
    memready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("fetch_alusrcb", {6'd0, alusrcb}, 8'h01);

    // fetch stall: three cycles without memready
    for (int i = 0; i < 3; i++) begin
      chk("stall_irwrite", {7'd0, irwrite}, 8'd0);
      chk("stall_state", {4'd0, state}, 8'd0);
      tick();
    end
    memready = 1'b1;
    op = 6'b000000;
    #1;
    chk("fetch_irwrite", {7'd0, irwrite}, 8'd1);
    chk("fetch_pcwrite", {7'd0, pcwrite}, 8'd1);
    tick();
    chk("dec_state", {4'd0, state}, 8'd1);
    chk("dec_irwrite", {7'd0, irwrite}, 8'd0);
    chk("dec_alusrcb", {6'd0, alusrcb}, 8'h03);
    tick();
    chk("rex_state", {4'd0, state}, 8'd6);
    chk("rex_aluop", {5'd0, aluop}, 8'h02);
    chk("rex_alusrca", {7'd0, alusrca}, 8'd1);
    tick();
    chk("rwb_state", {4'd0, state}, 8'd7);
    chk("rwb_regdst", {7'd0, regdst}, 8'd1);
    chk("rwb_regwrite", {7'd0, regwrite}, 8'd1);
    tick();
    chk("rwb_back", {4'd0, state}, 8'd0);

    // lw, memready held high: five cycles
    op = 6'b100011;
    tick();
    tick();
    chk("lw_madr", {4'd0, state}, 8'd2);
    chk("lw_madr_srcb", {6'd0, alusrcb}, 8'h02);
    tick();
    chk("lw_mrd", {4'd0, state}, 8'd3);
    chk("lw_mrd_iord", {7'd0, iord}, 8'd1);
    tick();
    chk("lw_mwb", {4'd0, state}, 8'd4);
    chk("lw_mwb_regwrite", {7'd0, regwrite}, 8'd1);
    chk("lw_mwb_memtoreg", {7'd0, memtoreg}, 8'd1);
    tick();
    chk("lw_done", {4'd0, state}, 8'd0);

    // sw
    op = 6'b101011;
    tick();
    tick();
    tick();
    chk("sw_mwr", {4'd0, state}, 8'd5);
    chk("sw_memwrite", {7'd0, memwrite}, 8'd1);
    tick();
    chk("sw_done", {4'd0, state}, 8'd0);

    // ori
    op = 6'b001101;
    tick();
    tick();
    chk("ori_state", {4'd0, state}, 8'd10);
    chk("ori_aluop", {5'd0, aluop}, 8'h04);
    chk("ori_zeroext", {7'd0, zeroext}, 8'd1);
    tick();
    chk("ori_wb", {4'd0, state}, 8'd11);
    chk("ori_wb_regwrite", {7'd0, regwrite}, 8'd1);
    chk("ori_wb_memtoreg", {7'd0, memtoreg}, 8'd0);
    tick();

    // slti
    op = 6'b001010;
    tick();
    tick();
    chk("slti_aluop", {5'd0, aluop}, 8'h07);
    chk("slti_zeroext", {7'd0, zeroext}, 8'd0);
    tick();
    tick();

    // bne
    op = 6'b000101;
    tick();
    tick();
    chk("bne_state", {4'd0, state}, 8'd9);
    chk("bne_aluop", {5'd0, aluop}, 8'h03);
    chk("bne_branchne", {7'd0, branchne}, 8'd1);
    chk("bne_branch", {7'd0, branch}, 8'd0);
    chk("bne_pcsrc", {6'd0, pcsrc}, 8'h01);
    tick();
    chk("bne_done", {4'd0, state}, 8'd0);

    // j
    op = 6'b000010;
    tick();
    tick();
    chk("j_state", {4'd0, state}, 8'd12);
    chk("j_pcwrite", {7'd0, pcwrite}, 8'd1);
    chk("j_pcsrc", {6'd0, pcsrc}, 8'h02);
    tick();
    chk("j_done", {4'd0, state}, 8'd0);

    // reset pulse while stalled in MEMRD
    op = 6'b100011;
    tick();
    tick();
    memready = 1'b0;
    tick();
    tick();
    chk("mrd_hold", {4'd0, state}, 8'd3);
    chk("mrd_regwrite", {7'd0, regwrite}, 8'd0);
    #2 reset = 1'b1;
    memready = 1'b1;
    #1;
    chk("async_rst_state", {4'd0, state}, 8'd0);
    chk("async_rst_regwrite", {7'd0, regwrite}, 8'd0);
    chk("async_rst_irwrite", {7'd0, irwrite}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_irwrite", {7'd0, irwrite}, 8'd1);

    // unknown opcode
    op = 6'b111111;
    tick();
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("ill_state", {4'd0, state}, 8'd13);
    chk("ill_flag", {7'd0, illegal}, 8'd1);
    chk("ill_pcwrite", {7'd0, pcwrite}, 8'd0);
    tick();
    tick();
    chk("ill_hold", {4'd0, state}, 8'd13);
    chk("ill_flag_hold", {7'd0, illegal}, 8'd1);
    reset = 1'b1;
    #1;
    chk("ill_rst_flag", {7'd0, illegal}, 8'd0);
    reset = 1'b0;
`else
    chk("ill_state", {4'd0, state}, 8'd0);
    chk("ill_flag", {7'd0, illegal}, 8'd0);
    tick();
    chk("ill_refetch", {4'd0, state}, 8'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
